acm_config_sequencer: RTL and testbench
=======================================

Name: acm_config_sequencer

Overview:
Drives the ACM lookup table's address input and consumes its data/valid outputs. Walks a programmed address range and turns each valid table entry into an APB write to the ACM configuration port. It sits between the CoreABC control logic, which pulses START, and the ACM APB slave. It replaces per-entry software writes with a hardware sequence.

Parameters:
ACM_BASE, 8'h00, offset added (mod 256) to table address to form PADDR
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (2..255)

Ports:
PCLK  input  1  system clock, all logic rising-edge
NSYSRESET  input  1  asynchronous active-low reset
START  input  1  begin sequence; sampled only in IDLE
FIRST_ADDR  input  8  first table address; captured on accepted START
LAST_ADDR  input  8  last table address, inclusive; captured on accepted START
ACMADDR  output  8  address to lookup table (registered)
ACMDATA  input  8  table data for ACMADDR (combinational from table)
ACMDO  input  1  table entry valid
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction, 1=write
PADDR  output  8  APB address
PWDATA  output  8  APB write data
PRDATA  input  8  APB read data (used only with ACM_VERIFY_EN)
PREADY  input  1  APB ready
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse at sequence end
ERROR  output  1  sticky; cleared on next accepted START
SKIPCNT  output  8  count of entries with ACMDO=0, saturates at 255

Behaviour:
- Reset (async, NSYSRESET=0): state IDLE; every output 0, including ACMADDR, PADDR, PWDATA and SKIPCNT. Reset at any point, including mid-APB ACCESS, drops PSEL/PENABLE immediately and abandons the sequence.
- States: IDLE, LOOKUP, SETUP, ACCESS, [VSETUP, VACCESS], FIN.
- IDLE:
  - START=1 captures FIRST/LAST, loads ACMADDR=FIRST_ADDR, clears SKIPCNT and ERROR.
  - If FIRST_ADDR>LAST_ADDR, goes to FIN with no APB activity; otherwise goes to LOOKUP.
- LOOKUP: ACMADDR has been stable for one cycle; ACMDATA/ACMDO are sampled at the end of this cycle.
  - ACMDO=1: latch PADDR=ACMADDR+ACM_BASE, PWDATA=ACMDATA, PWRITE=1; go to SETUP.
  - ACMDO=0: SKIPCNT++ (saturating); advance (see below).
- SETUP: PSEL=1, PENABLE=0, exactly one cycle; then ACCESS.
- ACCESS: PSEL=1, PENABLE=1; hold until PREADY=1, then deassert both and advance.
  - Timeout counter reloads on entry. TIMEOUT cycles with PREADY=0 sets ERROR=1, drops PSEL/PENABLE, goes to FIN.
- Advance:
  - If ACMADDR==LAST_ADDR, go to FIN. The compare happens before the increment, so LAST_ADDR=255 never wraps to 0.
  - Otherwise ACMADDR++ and go to LOOKUP.
- FIN: DONE=1 for one cycle, BUSY=1; then IDLE.
- Latency: a valid entry with zero-wait PREADY takes 3 cycles (LOOKUP, SETUP, ACCESS); a skipped entry takes 1 cycle. DONE is asserted 1 cycle after the last ACCESS/LOOKUP.
- START while BUSY=1 is ignored. START in the FIN cycle is ignored.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the completing ACCESS cycle and hold their last value afterward.

Optional Feature:
ACM_VERIFY_EN
- Defined: after each write ACCESS completes, the block does a read-back.
  - VSETUP: PWRITE=0, same PADDR.
  - VACCESS: wait for PREADY with the same timeout rule, then compare PRDATA to the written data.
  - Mismatch sets ERROR=1 and goes to FIN; match advances.
  - Valid-entry cost becomes 5 cycles at zero wait.
- Undefined: VSETUP/VACCESS are absent and PRDATA is unused. PWRITE still resets to 0 and is 1 during every transfer.

Test Plan:
1. Table entries are ACMDATA=~ACMADDR, ACMDO=0 only at 100. FIRST=0, LAST=3, PREADY=1 -> writes (0,FF),(1,FE),(2,FD),(3,FC); DONE 13 cycles after START-sample edge; SKIPCNT=0; ERROR=0.
2. FIRST=98, LAST=102 -> 4 writes at PADDR 98, 99, 101, 102; none at 100; SKIPCNT=1.
3. FIRST=254, LAST=255, ACM_BASE=8'h10 -> writes (0E,01), (0F,00); DONE; ACMADDR never returns to 0 within the sequence.
4. FIRST=5, LAST=5, PREADY stuck 0 -> PENABLE high 16 cycles, then PSEL/PENABLE=0, ERROR=1, DONE pulse. Next START clears ERROR.
5. Reset mid-sequence, START during BUSY, and an empty range:
   - FIRST=0, LAST=50; NSYSRESET low during an ACCESS -> all outputs 0 immediately, no DONE.
   - START pulsed while BUSY -> no restart.
   - FIRST=9, LAST=3 -> DONE 2 cycles after START, no PSEL.
6. ACM_VERIFY_EN defined, slave returns PRDATA=00 for address 0 -> write (0,FF), read back mismatch, ERROR=1, DONE, no write to address 1.

Source files
------------

// File: rtl/acm_config_sequencer.sv
// ACM configuration sequencer: walks a lookup-table address range and turns
// every valid entry into an APB write. Optional read-back check: ACM_VERIFY_EN.
module acm_config_sequencer #(
    parameter logic [7:0]  ACM_BASE = 8'h00,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic       PCLK,
    input  logic       NSYSRESET,
    input  logic       START,
    input  logic [7:0] FIRST_ADDR,
    input  logic [7:0] LAST_ADDR,
    output logic [7:0] ACMADDR,
    input  logic [7:0] ACMDATA,
    input  logic       ACMDO,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [7:0] SKIPCNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SETUP,
        S_ACCESS,
`ifdef ACM_VERIFY_EN
        S_VSETUP,
        S_VACCESS,
`endif
        S_FIN
    } state_t;

    // Counter reloads to TIMEOUT-1 so PENABLE stays high exactly TIMEOUT cycles.
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] last_q;
    logic [7:0] addr_q;
    logic       psel_q;
    logic       pen_q;
    logic       pwrite_q;
    logic [7:0] paddr_q;
    logic [7:0] pwdata_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic [7:0] skip_q;
    logic [7:0] tmo_q;

    logic       at_last;
    logic [7:0] addr_inc;

    // Range end is tested before increment so LAST_ADDR=255 never wraps.
    assign at_last  = (addr_q == last_q);
    assign addr_inc = addr_q + 8'd1;

`ifndef ACM_VERIFY_EN
    logic unused_prdata;
    assign unused_prdata = ^PRDATA;
`endif

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge PCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_q  <= S_IDLE;
            last_q   <= 8'h00;
            addr_q   <= 8'h00;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= 8'h00;
            pwdata_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            skip_q   <= 8'h00;
            tmo_q    <= 8'h00;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        last_q <= LAST_ADDR;
                        addr_q <= FIRST_ADDR;
                        skip_q <= 8'h00;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (FIRST_ADDR > LAST_ADDR) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (ACMDO) begin
                        paddr_q  <= addr_q + ACM_BASE;
                        pwdata_q <= ACMDATA;
                        pwrite_q <= 1'b1;
                        psel_q   <= 1'b1;
                        state_q  <= S_SETUP;
                    end else begin
                        if (skip_q != 8'hFF) begin
                            skip_q <= skip_q + 8'd1;
                        end
                        if (at_last) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_inc;
                            state_q <= S_LOOKUP;
                        end
                    end
                end
                S_SETUP: begin
                    pen_q   <= 1'b1;
                    tmo_q   <= TMO_LOAD;
                    state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        pen_q <= 1'b0;
`ifdef ACM_VERIFY_EN
                        pwrite_q <= 1'b0;
                        state_q  <= S_VSETUP;
`else
                        psel_q <= 1'b0;
                        if (at_last) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_inc;
                            state_q <= S_LOOKUP;
                        end
`endif
                    end else if (tmo_q == 8'h00) begin
                        err_q   <= 1'b1;
                        psel_q  <= 1'b0;
                        pen_q   <= 1'b0;
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
`ifdef ACM_VERIFY_EN
                S_VSETUP: begin
                    pen_q   <= 1'b1;
                    tmo_q   <= TMO_LOAD;
                    state_q <= S_VACCESS;
                end
                S_VACCESS: begin
                    if (PREADY) begin
                        psel_q <= 1'b0;
                        pen_q  <= 1'b0;
                        if (PRDATA != pwdata_q) begin
                            err_q   <= 1'b1;
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else if (at_last) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_inc;
                            state_q <= S_LOOKUP;
                        end
                    end else if (tmo_q == 8'h00) begin
                        err_q   <= 1'b1;
                        psel_q  <= 1'b0;
                        pen_q   <= 1'b0;
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
`endif
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    psel_q  <= 1'b0;
                    pen_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ACMADDR = addr_q;
    assign PSEL    = psel_q;
    assign PENABLE = pen_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERROR   = err_q;
    assign SKIPCNT = skip_q;

endmodule

// File: tb/tb_acm_config_sequencer.sv
// Scoreboard bench for acm_config_sequencer: expected APB transfers are
// queued by the stimulus and popped by an independent APB monitor.
module tb_acm_config_sequencer;

    localparam logic [7:0] BASE = 8'h10;

    logic       PCLK = 1'b0;
    logic       rst_n;
    logic       START;
    logic [7:0] FIRST_ADDR, LAST_ADDR;
    logic [7:0] ACMADDR;
    logic [7:0] ACMDATA;
    logic       ACMDO;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PREADY;
    logic       BUSY, DONE, ERROR;
    logic [7:0] SKIPCNT;

    logic [16:0] expq[$];
    logic [7:0]  smem[256];
    logic        bad_mode;
    int n_cmp = 0;
    int n_err = 0;
    int pen_cnt = 0;
    int psel_cnt = 0;
    bit saw_zero = 0;

    acm_config_sequencer #(.ACM_BASE(BASE), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .NSYSRESET(rst_n), .START(START),
        .FIRST_ADDR(FIRST_ADDR), .LAST_ADDR(LAST_ADDR),
        .ACMADDR(ACMADDR), .ACMDATA(ACMDATA), .ACMDO(ACMDO),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .BUSY(BUSY), .DONE(DONE),
        .ERROR(ERROR), .SKIPCNT(SKIPCNT)
    );

    always #5 PCLK = ~PCLK;

    // Lookup table: data is the inverted address, entry 100 invalid.
    assign ACMDATA = ~ACMADDR;
    assign ACMDO   = (ACMADDR != 8'd100);

    // APB slave: stores writes; can corrupt the read-back of table addr 0.
    assign PRDATA = (bad_mode && PADDR == BASE) ? 8'h00 : smem[PADDR];
    always @(posedge PCLK)
        if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every completing APB transfer is matched against the queue.
    always @(negedge PCLK) begin
        if (rst_n && PSEL && PENABLE && PREADY) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL apb_unexpected: got w=%b a=%h d=%h expected none",
                         PWRITE, PADDR, PWDATA);
            end else begin
                chk("apb_xfer", {15'd0, PWRITE, PADDR, PWDATA},
                    {15'd0, expq.pop_front()});
            end
        end
    end

    // Activity counters used by individual tests.
    always @(negedge PCLK) begin
        if (PENABLE) pen_cnt++;
        if (PSEL) psel_cnt++;
        if (BUSY && ACMADDR == 8'd0) saw_zero = 1;
    end

    task automatic push_w(input logic [7:0] a);
        logic [7:0] pa;
        logic [7:0] d;
        pa = a + BASE;
        d  = ~a;
        expq.push_back({1'b1, pa, d});
`ifdef ACM_VERIFY_EN
        expq.push_back({1'b0, pa, d});
`endif
    endtask

    task automatic start_seq(input logic [7:0] f, input logic [7:0] l);
        @(negedge PCLK);
        START = 1'b1;
        FIRST_ADDR = f;
        LAST_ADDR = l;
        @(negedge PCLK);
        START = 1'b0;
    endtask

    // k counts cycles after the START-sample edge; -1 if DONE never came.
    task automatic wait_done(input int maxc, output int k);
        bit got;
        got = 0;
        k = 0;
        while (k < maxc && !got) begin
            k++;
            if (DONE) got = 1;
            else @(negedge PCLK);
        end
        if (!got) begin
            k = -1;
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no DONE expected DONE within %0d", maxc);
        end
    endtask

    initial begin
        int k;
        bit hit;
        bit dn;
        rst_n = 1'b0;
        START = 1'b0;
        FIRST_ADDR = 8'h00;
        LAST_ADDR = 8'h00;
        PREADY = 1'b1;
        bad_mode = 1'b0;
        #1;
        chk("reset_outs", {ACMADDR, PADDR, PWDATA, SKIPCNT},  32'h0);
        chk("reset_ctl", {PSEL, PENABLE, PWRITE, BUSY, DONE, ERROR}, 32'h0);
        repeat (3) @(negedge PCLK);
        rst_n = 1'b1;

        // 1: four consecutive valid entries
        for (int a = 0; a < 4; a++) push_w(8'(a));
        start_seq(8'd0, 8'd3);
        wait_done(100, k);
`ifdef ACM_VERIFY_EN
        chk("t1_done_lat", k, 21);
`else
        chk("t1_done_lat", k, 13);
`endif
        chk("t1_skip", SKIPCNT, 0);
        chk("t1_err", ERROR, 0);
        chk("t1_busy_fin", BUSY, 1);

        // 2: range containing the invalid entry 100
        push_w(8'd98);
        push_w(8'd99);
        push_w(8'd101);
        push_w(8'd102);
        start_seq(8'd98, 8'd102);
        wait_done(100, k);
`ifdef ACM_VERIFY_EN
        chk("t2_done_lat", k, 22);
`else
        chk("t2_done_lat", k, 14);
`endif
        chk("t2_skip", SKIPCNT, 1);

        // 3: top of address space with base offset wrap
        push_w(8'd254);
        push_w(8'd255);
        saw_zero = 0;
        start_seq(8'd254, 8'd255);
        wait_done(100, k);
        chk("t3_done", k > 0, 1);
        chk("t3_no_wrap", saw_zero, 0);
        chk("t3_addr_end", ACMADDR, 8'hFF);

        // 4: PREADY stuck low times out
        PREADY = 1'b0;
        pen_cnt = 0;
        start_seq(8'd5, 8'd5);
        wait_done(100, k);
        chk("t4_done", k > 0, 1);
        chk("t4_pen_cycles", pen_cnt, 16);
        chk("t4_psel_pen", {PSEL, PENABLE}, 0);
        chk("t4_err", ERROR, 1);
        @(negedge PCLK);
        chk("t4_err_sticky", ERROR, 1);
        PREADY = 1'b1;
        push_w(8'd5);
        start_seq(8'd5, 8'd5);
        chk("t4_err_clear", ERROR, 0);
        wait_done(100, k);
        chk("t4_err_after", ERROR, 0);

        // 5a: reset during an ACCESS
        for (int a = 0; a <= 50; a++) push_w(8'(a));
        start_seq(8'd0, 8'd50);
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge PCLK);
            if (PENABLE && PWRITE && ACMADDR == 8'd3) hit = 1;
        end
        chk("t5_reached_access", hit, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {ACMADDR, PADDR, PWDATA, SKIPCNT}, 32'h0);
        chk("t5_rst_ctl", {PSEL, PENABLE, PWRITE, BUSY, DONE, ERROR}, 32'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        rst_n = 1'b1;
        expq.delete();
        dn = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (DONE || BUSY) dn = 1;
        end
        chk("t5_no_done", dn, 0);

        // 5b: START while busy and during FIN is ignored
        push_w(8'd10);
        push_w(8'd11);
        start_seq(8'd10, 8'd11);
        START = 1'b1;
        FIRST_ADDR = 8'd40;
        LAST_ADDR = 8'd41;
        @(negedge PCLK);
        START = 1'b0;
        wait_done(100, k);
        chk("t5_busy_done", k > 0, 1);
        START = 1'b1;
        @(negedge PCLK);
        START = 1'b0;
        chk("t5_fin_start", BUSY, 0);
        repeat (4) @(negedge PCLK);
        chk("t5_no_restart", BUSY, 0);
        chk("t5_queue", expq.size(), 0);

        // 5c: empty range
        psel_cnt = 0;
        start_seq(8'd9, 8'd3);
        wait_done(5, k);
        chk("t5_empty_done", (k > 0 && k <= 2), 1);
        chk("t5_empty_psel", psel_cnt, 0);

`ifdef ACM_VERIFY_EN
        // 6: read-back mismatch at address 0
        @(negedge PCLK);
        bad_mode = 1'b1;
        push_w(8'd0);
        start_seq(8'd0, 8'd1);
        wait_done(100, k);
        chk("t6_done", k > 0, 1);
        chk("t6_err", ERROR, 1);
        repeat (3) @(negedge PCLK);
        bad_mode = 1'b0;
`endif

        repeat (3) @(negedge PCLK);
        chk("final_queue", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
